// File: rtl/tm_feedback_sched_pkg.sv
// tm_fb_pkg: shared definitions for the Tsetlin feedback scheduler.
//   - feedback type encodings carried on fb_type
//   - scheduler FSM state encoding
//   - Galois LFSR feedback polynomial
//   - fb_mask: smallest all-ones mask covering the MSB of its argument
package tm_fb_pkg;

  localparam logic [1:0] FB_NONE    = 2'b00;
  localparam logic [1:0] FB_TYPE_I  = 2'b01;
  localparam logic [1:0] FB_TYPE_II = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } fb_state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Smear the highest set bit downward so the result is all-ones up to it
  function automatic logic [15:0] fb_mask(input logic [15:0] x);
    logic [15:0] m;
    m = x;
    for (int i = 1; i < 16; i++) begin
      m = m | (x >> i);
    end
    return m;
  endfunction

endpackage

// File: rtl/tm_feedback_sched_lfsr.sv
// tm_lfsr16: 16-bit right-shifting Galois LFSR.
//   clk, rst_n : clock, async active-low reset (loads SEED)
//   adv        : advance one step this cycle
//   lfsr       : current state (never zero for a nonzero SEED)
module tm_lfsr16
  import tm_fb_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_r;

  // State register: shift right, fold the polynomial in when a 1 drops out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (adv) begin
      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_POLY : 16'h0000);
    end
  end

  assign lfsr = lfsr_r;

endmodule

// File: rtl/tm_feedback_sched.sv
// tm_feedback_sched: walks the clauses of one class, selects each clause with
// probability d/T using rejection-sampled LFSR draws, and issues a Type I /
// Type II feedback command per selected clause over valid/ready.
//   clk, rst_n         : clock, async active-low reset
//   start              : begin a pass (only honoured while idle)
//   T, q, d            : hyperparameter, target flag, threshold (latched on start)
//   busy, done         : pass in progress / one-cycle end-of-pass pulse
//   fb_valid, fb_ready : feedback handshake
//   fb_clause, fb_type : selected clause index and feedback type
module tm_feedback_sched
  import tm_fb_pkg::*;
#(
  parameter int          T_WIDTH   = 8,
  parameter int          N_CLAUSES = 16,
  parameter int          CIDX_W    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [T_WIDTH:0]   T,
  input  logic               q,
  input  logic [T_WIDTH-1:0] d,
  output logic               busy,
  output logic               done,
  output logic               fb_valid,
  input  logic               fb_ready,
  output logic [CIDX_W-1:0]  fb_clause,
  output logic [1:0]         fb_type
);

  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(N_CLAUSES - 1);

  fb_state_e            state_r, state_nxt_s;
  logic [CIDX_W-1:0]    idx_r, idx_nxt_s;
  logic [T_WIDTH:0]     t_r;
  logic [T_WIDTH-1:0]   d_r;
  logic [T_WIDTH-1:0]   mask_r;
  logic                 q_r;
  logic [15:0]          lfsr_s;
  logic                 adv_s;
  logic [T_WIDTH:0]     r_ext_s;
  logic [T_WIDTH:0]     d_ext_s;
  logic                 last_s;
  logic                 busy_r, done_r, fb_valid_r;
  logic [CIDX_W-1:0]    fb_clause_r;
  logic [1:0]           fb_type_r;

  tm_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv_s),
    .lfsr  (lfsr_s)
  );

  // Masked draw is uniform over a power-of-two range; values >= T get rejected
  assign r_ext_s = {1'b0, T_WIDTH'(lfsr_s) & mask_r};
  assign d_ext_s = {1'b0, d_r};
  assign last_s  = (idx_r == LAST_IDX);

  // Pass parameters are captured once per accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r    <= {(T_WIDTH+1){1'b0}};
      d_r    <= {T_WIDTH{1'b0}};
      q_r    <= 1'b0;
      mask_r <= {T_WIDTH{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      t_r    <= T;
      d_r    <= d;
      q_r    <= q;
      mask_r <= T_WIDTH'(fb_mask(16'(T) - 16'd1));
    end
  end

  // Next-state, clause index and LFSR advance
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    adv_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          idx_nxt_s = {CIDX_W{1'b0}};
          if ((d == {T_WIDTH{1'b0}}) || (T == {(T_WIDTH+1){1'b0}})) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = DRAW;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAW: begin
        if (d_ext_s >= t_r) begin
          // Certain selection: no draw needed, LFSR holds
          state_nxt_s = EMIT;
        end else begin
          adv_s = 1'b1;
          if (r_ext_s >= t_r) begin
            state_nxt_s = DRAW;
          end else if (r_ext_s < d_ext_s) begin
            state_nxt_s = EMIT;
          end else if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            idx_nxt_s = idx_r + CIDX_W'(1);
          end
        end
      end
      EMIT: begin
        if (fb_ready) begin
          if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            idx_nxt_s   = idx_r + CIDX_W'(1);
            state_nxt_s = DRAW;
          end
        end else begin
          state_nxt_s = EMIT;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State/index registers and outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= {CIDX_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fb_valid_r  <= 1'b0;
      fb_clause_r <= {CIDX_W{1'b0}};
      fb_type_r   <= FB_NONE;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
      fb_valid_r  <= (state_nxt_s == EMIT);
      fb_clause_r <= (state_nxt_s == EMIT) ? idx_nxt_s : {CIDX_W{1'b0}};
      // Even clauses are positive polarity: Type I when q=1, Type II when q=0
      if (state_nxt_s == EMIT) begin
        fb_type_r <= (idx_nxt_s[0] != q_r) ? FB_TYPE_I : FB_TYPE_II;
      end else begin
        fb_type_r <= FB_NONE;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign fb_valid  = fb_valid_r;
  assign fb_clause = fb_clause_r;
  assign fb_type   = fb_type_r;

endmodule

// File: tb/tb_tm_feedback_sched.sv
// Bench for tm_feedback_sched: a 4-clause instance for directed sequencing,
// stall, start-while-busy and reset tests, and a 16-clause instance checked
// against a bit-exact LFSR reference model over 1000 passes.
module tb_tm_feedback_sched;

  logic       clk = 1'b0;
  logic       rst_n, start4, start16, fb_ready, q;
  logic [8:0] T;
  logic [7:0] d;
  logic       busy4, done4, v4, busy16, done16, v16;
  logic [1:0] cl4, ty4, ty16;
  logic [3:0] cl16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tm_feedback_sched #(.T_WIDTH(8), .N_CLAUSES(4), .CIDX_W(2), .LFSR_SEED(16'hACE1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .T(T), .q(q), .d(d),
    .busy(busy4), .done(done4), .fb_valid(v4), .fb_ready(fb_ready),
    .fb_clause(cl4), .fb_type(ty4));

  tm_feedback_sched #(.T_WIDTH(8), .N_CLAUSES(16), .CIDX_W(4), .LFSR_SEED(16'hACE1)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .T(T), .q(q), .d(d),
    .busy(busy16), .done(done16), .fb_valid(v16), .fb_ready(fb_ready),
    .fb_clause(cl16), .fb_type(ty16));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Even clause with q=1, or odd clause with q=0, gets Type I (2'b01)
  function automatic logic [1:0] exp_type(input int cl, input logic qq);
    return (((cl % 2) == 0) == qq) ? 2'b01 : 2'b10;
  endfunction

  // Reference pass: selected-clause set and start-to-done cycle count (fb_ready high)
  task automatic model_pass(input int n, input int tt, input int dd, input logic [7:0] mask,
                            inout logic [15:0] lf, output logic [15:0] sel, output int cyc);
    logic [7:0] r;
    sel = 16'h0000;
    cyc = 1;
    for (int i = 0; i < n; i++) begin
      if (dd >= tt) begin
        sel[i] = 1'b1;
        cyc += 2;
      end else begin
        do begin
          r  = lf[7:0] & mask;
          lf = lfsr_step(lf);
          cyc++;
        end while (int'(r) >= tt);
        if (int'(r) < dd) begin
          sel[i] = 1'b1;
          cyc++;
        end
      end
    end
  endtask

  // Drive one pass on the chosen instance, scramble inputs, collect emits
  task automatic run_pass(input bit big, input logic qq, input int tt, input int dd,
                          output logic [15:0] seen, output int cyc);
    logic v, dn, bz;
    logic [3:0] cl;
    logic [1:0] ty;
    bit fin;
    T = 9'(tt); d = 8'(dd); q = qq;
    if (big) start16 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; start4 = 1'b0;
    T = 9'd1; d = 8'd0; q = ~qq;
    seen = 16'h0000; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 4000) begin
      cyc++;
      v  = big ? v16 : v4;
      dn = big ? done16 : done4;
      bz = big ? busy16 : busy4;
      cl = big ? cl16 : {2'b00, cl4};
      ty = big ? ty16 : ty4;
      check_eq("busy_in_pass", 32'(bz), 32'd1);
      if (v) begin
        seen[cl] = 1'b1;
        check_eq("emit_type", 32'(ty), 32'(exp_type(int'(cl), qq)));
      end
      if (dn) fin = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!fin) check_eq("pass_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] lf, sel, seen;
    logic [7:0]  r;
    int cyc, mcyc, first, total_sel, wait_cnt;

    rst_n = 1'b0; start4 = 1'b0; start16 = 1'b0; fb_ready = 1'b1;
    q = 1'b0; T = 9'd0; d = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_busy", 32'(busy4), 32'd0);
    check_eq("rst_done", 32'(done4), 32'd0);
    check_eq("rst_valid", 32'(v4), 32'd0);
    check_eq("rst_clause", 32'(cl4), 32'd0);
    check_eq("rst_type", 32'(ty4), 32'd0);
    check_eq("rst_lfsr", 32'(u4.lfsr_s), 32'hACE1);

    // d=0: done the cycle after start, nothing emitted, LFSR untouched
    T = 9'd36; d = 8'd0; q = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check_eq("d0_done", 32'(done4), 32'd1);
    check_eq("d0_busy", 32'(busy4), 32'd1);
    check_eq("d0_valid", 32'(v4), 32'd0);
    @(posedge clk); #1;
    check_eq("d0_done_clr", 32'(done4), 32'd0);
    check_eq("d0_idle", 32'(busy4), 32'd0);
    check_eq("d0_valid2", 32'(v4), 32'd0);
    check_eq("d0_lfsr", 32'(u4.lfsr_s), 32'hACE1);

    // d>=T: every clause selected in order, done 9 cycles after start; q=1 then q=0
    for (int qi = 0; qi < 2; qi++) begin
      T = 9'd36; d = 8'd36; q = (qi == 0); fb_ready = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        if (k > 1) begin @(posedge clk); #1; end
        check_eq("all_valid", 32'(v4), 32'((k % 2 == 0) && (k < 9)));
        if ((k % 2 == 0) && (k < 9)) begin
          check_eq("all_clause", 32'(cl4), 32'(k / 2 - 1));
          check_eq("all_type", 32'(ty4), 32'(exp_type(k / 2 - 1, (qi == 0))));
        end
        check_eq("all_done", 32'(done4), 32'(k == 9));
        check_eq("all_busy", 32'(busy4), 32'd1);
      end
      @(posedge clk); #1;
      check_eq("all_idle", 32'(busy4), 32'd0);
    end

    // Stall: fb_ready low for 5 cycles at the first emit (d=18, LFSR from seed)
    lf = 16'hACE1; first = -1;
    for (int i = 0; i < 4 && first < 0; i++) begin
      do begin
        r  = lf[7:0] & 8'h3F;
        lf = lfsr_step(lf);
      end while (int'(r) >= 36);
      if (int'(r) < 18) first = i;
    end
    fb_ready = 1'b0; T = 9'd36; d = 8'd18; q = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_cnt = 0;
    while (!v4 && wait_cnt < 200) begin @(posedge clk); #1; wait_cnt++; end
    check_eq("stall_reached", 32'(v4), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_valid", 32'(v4), 32'd1);
      check_eq("stall_clause", 32'(cl4), 32'(first));
      check_eq("stall_type", 32'(ty4), 32'(exp_type(first, 1'b1)));
      check_eq("stall_busy", 32'(busy4), 32'd1);
      check_eq("stall_lfsr", 32'(u4.lfsr_s), 32'(lf));
      @(posedge clk); #1;
    end
    fb_ready = 1'b1;
    wait_cnt = 0;
    while (!done4 && wait_cnt < 400) begin @(posedge clk); #1; wait_cnt++; end
    check_eq("stall_done", 32'(done4), 32'd1);
    @(posedge clk); #1;

    // start while busy and changing inputs: no relatch, single done
    T = 9'd36; d = 8'd36; q = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 3) begin start4 = 1'b1; q = 1'b0; d = 8'd0; T = 9'd0; end
      if (k == 4) start4 = 1'b0;
      check_eq("sb_valid", 32'(v4), 32'((k % 2 == 0) && (k < 9)));
      if ((k % 2 == 0) && (k < 9))
        check_eq("sb_type", 32'(ty4), 32'(exp_type(k / 2 - 1, 1'b1)));
      check_eq("sb_done", 32'(done4), 32'(k == 9));
      check_eq("sb_busy", 32'(busy4), 32'(k <= 9));
    end

    // Reset during EMIT, then the first d=18 pass must replay from the seed
    fb_ready = 1'b0; T = 9'd36; d = 8'd18; q = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_cnt = 0;
    while (!v4 && wait_cnt < 200) begin @(posedge clk); #1; wait_cnt++; end
    check_eq("rstemit_reached", 32'(v4), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstemit_valid", 32'(v4), 32'd0);
    check_eq("rstemit_busy", 32'(busy4), 32'd0);
    check_eq("rstemit_clause", 32'(cl4), 32'd0);
    check_eq("rstemit_type", 32'(ty4), 32'd0);
    check_eq("rstemit_lfsr", 32'(u4.lfsr_s), 32'hACE1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("rstemit_nodone", 32'(done4), 32'd0);
      check_eq("rstemit_idle", 32'(busy4), 32'd0);
    end
    fb_ready = 1'b1;
    lf = 16'hACE1;
    model_pass(4, 36, 18, 8'h3F, lf, sel, mcyc);
    run_pass(1'b0, 1'b1, 36, 18, seen, cyc);
    check_eq("replay_set", 32'(seen), 32'(sel));
    check_eq("replay_cycles", 32'(cyc), 32'(mcyc));

    // 1000 passes of 16 clauses against the reference model
    lf = 16'hACE1; total_sel = 0;
    for (int p = 0; p < 1000; p++) begin
      model_pass(16, 36, 18, 8'h3F, lf, sel, mcyc);
      run_pass(1'b1, 1'(p % 2), 36, 18, seen, cyc);
      check_eq("rand_set", 32'(seen), 32'(sel));
      check_eq("rand_cycles", 32'(cyc), 32'(mcyc));
      total_sel += $countones(seen);
    end
    check_eq("rand_rate", 32'((total_sel >= 7520) && (total_sel <= 8480)), 32'd1);
    check_eq("rand_lfsr_end", 32'(u16.lfsr_s), 32'(lf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm_feedback_sched.md
Name: tm_feedback_sched

Overview:
- Tsetlin training stage directly downstream of the Type II probability block (d_prob).
- Takes the latched probability d, target flag q and hyperparameter T.
- Walks every clause of one class. For each clause, draws a uniform random value in [0, T-1] and selects the clause when that value is below d.
- For each selected clause, issues a feedback command (Type I or Type II, chosen by clause polarity and q) over a valid/ready interface to the clause-update stage.

Parameters:
- T_WIDTH, 8, width of d; T is T_WIDTH+1 bits.
- N_CLAUSES, 16, clauses per class; must be ≥2.
- CIDX_W, 4, clause index width; must satisfy 2^CIDX_W ≥ N_CLAUSES.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- start, input, 1, one-cycle request to begin a pass; ignored while busy.
- T, input, T_WIDTH+1, hyperparameter, unsigned; sampled on start.
- q, input, 1, target flag (1 = positive sample); sampled on start.
- d, input, T_WIDTH, selection threshold from d_prob; sampled on start.
- busy, output, 1, high from the cycle after an accepted start until DONE exits.
- done, output, 1, one-cycle pulse at end of pass.
- fb_valid, output, 1, feedback command valid.
- fb_ready, input, 1, consumer ready.
- fb_clause, output, CIDX_W, index of the selected clause.
- fb_type, output, 2, feedback type: FB_TYPE_I = 2'b01, FB_TYPE_II = 2'b10.

Behaviour:
- Reset: clk, async active-low rst_n. All outputs 0; state IDLE; clause index 0; LFSR = LFSR_SEED. Reset mid-pass aborts the pass; no done pulse is issued.
- Latch on accepted start (IDLE and start): capture T, q, d, and mask.
  - mask = all-ones covering the MSB of (T-1). Example: T=36 gives mask 0x3F; T=1 gives mask 0.
  - Clause index set to 0.
- IDLE → DONE directly if d==0 or T==0. Otherwise IDLE → DRAW.
- DRAW (one draw per cycle):
  - r = lfsr[T_WIDTH-1:0] & mask; the LFSR advances every DRAW cycle.
  - If r ≥ T: reject, stay in DRAW, same clause.
  - Else the clause is selected iff r < d.
  - If d ≥ T: every clause is selected without drawing, and the LFSR does not advance.
  - Selected clause → EMIT.
  - Not selected: if last clause → DONE, else index+1 and stay in DRAW.
- EMIT:
  - fb_valid=1. fb_clause = index.
  - fb_type: even index = positive polarity, odd index = negative polarity. If q=1, positive clauses get TYPE_I and negative get TYPE_II; if q=0, the mapping is swapped.
  - Holds fb_valid, fb_clause and fb_type stable until fb_ready; the LFSR is frozen meanwhile.
  - On the fb_valid & fb_ready cycle: if last clause → DONE, else index+1 → DRAW.
- DONE: done=1 for one cycle, busy=1 → IDLE.
- Latency:
  - Pass with d==0: start at cycle n, done at n+1.
  - Pass with d ≥ T and fb_ready tied high: 2·N_CLAUSES+1 cycles from start to done.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Shift right; XOR mask when the shifted-out bit is 1. Never reaches 0.
- Arithmetic: all comparisons unsigned. The masked draw stays within T_WIDTH bits because T ≤ 2^T_WIDTH.
- Inputs change freely while busy without effect.

Decomposition:
- Package tm_fb_pkg:
  - fb_type encodings FB_NONE / FB_TYPE_I / FB_TYPE_II.
  - State encoding IDLE / DRAW / EMIT / DONE.
  - LFSR_POLY = 16'hB400.
- Sub-module tm_lfsr16: seed parameter, advance enable, 16-bit state output.
- Mask generation is a small function in the package.

Test Plan:
- d=0, T=36, q=1, start → done at the next cycle; fb_valid never asserted; LFSR unchanged.
- N_CLAUSES=4, T=36, d=36, q=1, fb_ready=1 → emits (0,TYPE_I), (1,TYPE_II), (2,TYPE_I), (3,TYPE_II); done 9 cycles after start. Repeat with q=0 → types swapped.
- Same pass, fb_ready held low 5 cycles at the first emit → fb_valid/fb_clause/fb_type stable for all 5 cycles; LFSR frozen; busy stays high.
- T=36, d=18, 1000 passes of 16 clauses against a bit-exact LFSR reference model:
  - emitted clause set matches the model exactly;
  - selection rate 0.5±0.03;
  - rejection occurs whenever masked r ∈ [36,63].
- start pulsed during busy → ignored: no relatch, no extra done.
- rst_n asserted during EMIT → outputs 0 immediately; LFSR = 16'hACE1; a new start then reproduces the first-pass sequence exactly.
